alu_issue_unit: RTL and testbench

- Front-end driver for the combinational ALU. It decodes a MIPS-style instruction word into the ALU's 4-bit operation code and operands.
- Registers the ALU operands for one execute cycle, captures the ALU result, and returns it with a valid/ready handshake.
- Sits between the register-read stage (upstream) and the ALU (downstream, combinational). Flags illegal instructions instead of issuing them.

---
 rtl/alu_issue_unit.sv | 209 ++++++++++++++++++++
 tb/tb_alu_issue_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// Issue front-end for a combinational ALU: decodes a MIPS-style instruction,
// holds the operands for one execute cycle and returns the captured result.
module alu_issue_unit #(
  parameter int CNT_W        = 16,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs,
  input  logic [31:0]      in_rt,
  output logic [3:0]       alu_ctrl,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [31:0]      alu_imm,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LUI = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        legal;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr,
                                  input logic [31:0] rs,
                                  input logic [31:0] rt);
    dec_t        d;
    logic [31:0] imm_sx;
    logic [31:0] imm_zx;
    logic [31:0] sh_b;
    logic [31:0] rsv_b;
    imm_sx  = {{16{instr[15]}}, instr[15:0]};
    imm_zx  = {16'h0000, instr[15:0]};
    sh_b    = {27'd0, instr[10:6]};
    rsv_b   = {27'd0, rs[4:0]};
    d.legal = 1'b1;
    d.ctrl  = OP_ADD;
    d.a     = rs;
    d.b     = rt;
    case (instr[31:26])
      6'h00: begin
        case (instr[5:0])
          6'h20, 6'h21: d.ctrl = OP_ADD;
          6'h22, 6'h23: d.ctrl = OP_SUB;
          6'h24:        d.ctrl = OP_AND;
          6'h25:        d.ctrl = OP_OR;
          6'h26:        d.ctrl = OP_XOR;
          6'h00: begin d.ctrl = OP_SLL; d.a = rt; d.b = sh_b;  end
          6'h02: begin d.ctrl = OP_SRL; d.a = rt; d.b = sh_b;  end
          6'h03: begin d.ctrl = OP_SRA; d.a = rt; d.b = sh_b;  end
          6'h04: begin d.ctrl = OP_SLL; d.a = rt; d.b = rsv_b; end
          6'h06: begin d.ctrl = OP_SRL; d.a = rt; d.b = rsv_b; end
          6'h07: begin d.ctrl = OP_SRA; d.a = rt; d.b = rsv_b; end
          default: d.legal = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin d.ctrl = OP_ADD; d.b = imm_sx; end
      6'h0C:        begin d.ctrl = OP_AND; d.b = imm_zx; end
      6'h0D:        begin d.ctrl = OP_OR;  d.b = imm_zx; end
      6'h0E:        begin d.ctrl = OP_XOR; d.b = imm_zx; end
      6'h0F:        begin d.ctrl = OP_LUI; d.a = 32'd0; d.b = imm_zx; end
      default:      d.legal = 1'b0;
    endcase
    return d;
  endfunction

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [31:0]      alu_imm_q, alu_imm_d;
  logic [31:0]      out_result_q, out_result_d;
  logic             out_zero_q, out_zero_d;
  logic             out_illegal_q, out_illegal_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  dec_t             dec;

  // Register-number fields are resolved upstream; only values arrive here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^in_instr[25:16];

  // Decode the offered instruction.
  always_comb begin
    dec = decode(in_instr, in_rs, in_rt);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    alu_ctrl_d    = alu_ctrl_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_imm_d     = alu_imm_q;
    out_result_d  = out_result_q;
    out_zero_d    = out_zero_q;
    out_illegal_d = out_illegal_q;
    op_count_d    = op_count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (dec.legal) begin
            alu_ctrl_d = dec.ctrl;
            alu_a_d    = dec.a;
            alu_b_d    = dec.b;
            alu_imm_d  = {{16{in_instr[15]}}, in_instr[15:0]};
            state_d    = EXEC;
          end else if (TRAP_ILLEGAL) begin
            out_result_d  = 32'd0;
            out_zero_d    = 1'b0;
            out_illegal_d = 1'b1;
            state_d       = RESP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        out_result_d  = alu_result;
        out_zero_d    = alu_zero;
        out_illegal_d = 1'b0;
        state_d       = RESP;
      end
      RESP: begin
        if (out_ready) begin
          op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d    = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are registered copies of the next state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == RESP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      alu_ctrl_q    <= 4'd0;
      alu_a_q       <= 32'd0;
      alu_b_q       <= 32'd0;
      alu_imm_q     <= 32'd0;
      out_result_q  <= 32'd0;
      out_zero_q    <= 1'b0;
      out_illegal_q <= 1'b0;
      op_count_q    <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      alu_ctrl_q    <= alu_ctrl_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_imm_q     <= alu_imm_d;
      out_result_q  <= out_result_d;
      out_zero_q    <= out_zero_d;
      out_illegal_q <= out_illegal_d;
      op_count_q    <= op_count_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_imm     = alu_imm_q;
  assign out_result  = out_result_q;
  assign out_zero    = out_zero_q;
  assign out_illegal = out_illegal_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: a trapping instance with a full counter and a
// non-trapping instance with a 2-bit counter, both driven by one stream.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr, in_rs, in_rt;
  logic        out_ready;

  logic        in_ready, out_valid, out_zero, out_illegal, alu_zero;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_imm, alu_result, out_result;
  logic [15:0] op_count;

  logic        in_ready0, out_valid0, out_zero0, out_illegal0, alu_zero0;
  logic [3:0]  alu_ctrl0;
  logic [31:0] alu_a0, alu_b0, alu_imm0, alu_result0, out_result0;
  logic [1:0]  op_count0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return {b[15:0], 16'h0000};
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      4'd8: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  assign alu_result  = alu_model(alu_ctrl, alu_a, alu_b);
  assign alu_zero    = (alu_result == 32'd0);
  assign alu_result0 = alu_model(alu_ctrl0, alu_a0, alu_b0);
  assign alu_zero0   = (alu_result0 == 32'd0);

  alu_issue_unit #(.CNT_W(16), .TRAP_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs(in_rs), .in_rt(in_rt),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal), .op_count(op_count));

  alu_issue_unit #(.CNT_W(2), .TRAP_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_rs(in_rs), .in_rt(in_rt),
    .alu_ctrl(alu_ctrl0), .alu_a(alu_a0), .alu_b(alu_b0), .alu_imm(alu_imm0),
    .alu_result(alu_result0), .alu_zero(alu_zero0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_result(out_result0),
    .out_zero(out_zero0), .out_illegal(out_illegal0), .op_count(op_count0));

  typedef struct {
    logic [31:0] instr, rs, rt;
    logic        ill;
    logic [3:0]  ctrl;
    logic [31:0] a, b, res;
    logic        z;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cnt1  = 0;
  int   cnt0  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] instr, rs, rt, input logic ill, input logic [3:0] ctrl,
                     input logic [31:0] a, b, res, input logic z);
    vec_t v;
    v.instr = instr; v.rs = rs; v.rt = rt; v.ill = ill; v.ctrl = ctrl;
    v.a = a; v.b = b; v.res = res; v.z = z;
    vecs.push_back(v);
  endtask

  task automatic apply_vec(input vec_t v);
    exp_t e;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b1; in_instr = v.instr; in_rs = v.rs; in_rt = v.rt; out_ready = 1'b0;
    e.res = v.res; e.z = v.z; e.ill = v.ill;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; in_rs = $urandom; in_rt = $urandom; in_instr = $urandom;
    if (!v.ill) begin
      chk("exec_out_valid", {31'd0, out_valid}, 32'd0);
      chk("exec_in_ready", {31'd0, in_ready}, 32'd0);
      chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, v.ctrl});
      chk("alu_a", alu_a, v.a);
      chk("alu_b", alu_b, v.b);
      chk("alu_imm", alu_imm, {{16{v.instr[15]}}, v.instr[15:0]});
      @(posedge clk); #1;
    end else begin
      chk("drop_in_ready0", {31'd0, in_ready0}, 32'd1);
      chk("drop_out_valid0", {31'd0, out_valid0}, 32'd0);
    end
    chk("resp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("resp_in_ready", {31'd0, in_ready}, 32'd0);
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: response with empty queue");
    end else begin
      e = sb.pop_front();
      chk("out_result", out_result, e.res);
      chk("out_zero", {31'd0, out_zero}, {31'd0, e.z});
      chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    cnt1++;
    if (!v.ill) cnt0++;
    chk("done_out_valid", {31'd0, out_valid}, 32'd0);
    chk("done_in_ready", {31'd0, in_ready}, 32'd1);
    chk("op_count", {16'd0, op_count}, cnt1);
    chk("op_count0_wrap", {30'd0, op_count0}, cnt0 % 4);
    n_vec++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc;
    vec_t v;
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_rs = 32'd0; in_rt = 32'd0; out_ready = 1'b0;

    //   instr         rs            rt           ill ctrl a             b             result        z
    add(32'h00851020, 32'd5,        32'd7,        0, 0, 32'd5,        32'd7,        32'd12,       0);
    add(32'h00851022, 32'h1234,     32'h1234,     0, 1, 32'h1234,     32'h1234,     32'd0,        1);
    add(32'h2000FFFF, 32'd1,        32'd0,        0, 0, 32'd1,        32'hFFFFFFFF, 32'd0,        1);
    add(32'h00000103, 32'd0,        32'h80000000, 0, 8, 32'h80000000, 32'd4,        32'hF8000000, 0);
    add(32'h00000007, 32'h24,       32'h80000000, 0, 8, 32'h80000000, 32'd4,        32'hF8000000, 0);
    add(32'h3C00ABCD, 32'h55,       32'd0,        0, 5, 32'd0,        32'h0000ABCD, 32'hABCD0000, 0);
    add(32'h00000024, 32'hF0F0FFFF, 32'h0FF0F00F, 0, 2, 32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F, 0);
    add(32'h00000025, 32'h12340000, 32'h00005678, 0, 3, 32'h12340000, 32'h00005678, 32'h12345678, 0);
    add(32'h00000026, 32'hFFFF0000, 32'hFF00FF00, 0, 4, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 0);
    add(32'h000007C0, 32'd0,        32'd3,        0, 6, 32'd3,        32'd31,       32'h80000000, 0);
    add(32'h00000202, 32'd0,        32'h80000000, 0, 7, 32'h80000000, 32'd8,        32'h00800000, 0);
    add(32'h34008001, 32'h10000000, 32'd0,        0, 3, 32'h10000000, 32'h00008001, 32'h10008001, 0);
    add(32'h00000021, 32'hFFFFFFFF, 32'd1,        0, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        1);
    add(32'h00000023, 32'd0,        32'd1,        0, 1, 32'd0,        32'd1,        32'hFFFFFFFF, 0);
    add(32'h3800FFFF, 32'hFFFF0000, 32'd0,        0, 4, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 0);
    add(32'h300000FF, 32'h12345678, 32'd0,        0, 2, 32'h12345678, 32'h000000FF, 32'h00000078, 0);
    add(32'hFC000000, 32'd1,        32'd2,        1, 0, 32'd0,        32'd0,        32'd0,        0);
    add(32'h00000006, 32'h21,       32'h10,       0, 7, 32'h10,       32'd1,        32'd8,        0);
    add(32'h24000010, 32'hFFFFFFF0, 32'd0,        0, 0, 32'hFFFFFFF0, 32'h10,       32'd0,        1);
    add(32'h00000004, 32'hFFFFFFE3, 32'd1,        0, 6, 32'd1,        32'd3,        32'd8,        0);
    add(32'h00000001, 32'd1,        32'd2,        1, 0, 32'd0,        32'd0,        32'd0,        0);
    add(32'h28000001, 32'd1,        32'd2,        1, 0, 32'd0,        32'd0,        32'd0,        0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_imm", alu_imm, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Backpressure: response must hold while out_ready stays low.
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00851020; in_rs = 32'd5; in_rt = 32'd7;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_result", out_result, 32'd12);
      chk("bp_out_zero", {31'd0, out_zero}, 32'd0);
      @(posedge clk); #1;
    end
    n_vec++;
    // Reset while a response is pending.
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_resp_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_resp_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_resp_op_count", {16'd0, op_count}, 32'd0);
    chk("rst_resp_op_count0", {30'd0, op_count0}, 32'd0);
    chk("rst_resp_out_result", out_result, 32'd0);
    chk("rst_resp_alu_b", alu_b, 32'd0);
    n_vec++;

    // Back-to-back with out_ready held high: one accept every 3 cycles.
    acc = 0;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00851020; in_rs = 32'd5; in_rt = 32'd7; out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      if (in_ready) acc++;
      if (c >= 1 && out_valid && in_ready) begin
        n_err++;
        $display("FAIL tput_overlap: out_valid=1 with in_ready=1");
      end
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("tput_accepts", acc, 32'd3);
    chk("tput_op_count", {16'd0, op_count}, 32'd3);
    chk("tput_op_count0", {30'd0, op_count0}, 32'd3);
    chk("tput_out_result", out_result, 32'd12);
    n_vec++;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
